// File: rtl/fetch_pkg.sv
// Shared fetch-stage types: redirect source indices, latency bound and the
// in-flight fetch entry record used by the fetch address sequencer.
package fetch_pkg;

   typedef enum logic [1:0] {
      REDIR_TRAP   = 2'd0,
      REDIR_BRANCH = 2'd1,
      REDIR_PRED   = 2'd2,
      REDIR_SPARE  = 2'd3
   } redirect_src_e;

   localparam int FETCH_LATENCY_MAX = 4;
   // Entry pc is sized for the widest supported address; users take [XLEN-1:0].
   localparam int FETCH_XLEN_MAX    = 64;

   typedef struct packed {
      logic                      valid;
      logic                      half;
      logic [FETCH_XLEN_MAX-1:0] pc;
   } fetch_entry_t;

endpackage

// File: rtl/redirect_priority_arbiter.sv
// Fixed-priority redirect encoder: the lowest set request index wins and its
// target is forwarded.
module redirect_priority_arbiter
   import fetch_pkg::*;
#(
   parameter int N    = 4,
   parameter int XLEN = 32
) (
   input  logic [N-1:0]         i_valid,
   input  logic [N*XLEN-1:0]    i_target,
   output logic                 o_fire,
   output logic [$clog2(N)-1:0] o_index,
   output logic [XLEN-1:0]      o_target
);

   localparam int IDX_W = $clog2(N);

   // priority scan, high index first so the lowest set index lands last
   always_comb begin
      o_fire   = |i_valid;
      o_index  = {IDX_W{1'b0}};
      o_target = {XLEN{1'b0}};
      for (int i = N - 1; i >= 0; i--) begin
         if (i_valid[i]) begin
            o_index  = i[IDX_W-1:0];
            o_target = i_target[i*XLEN +: XLEN];
         end else begin
            o_index  = o_index;
            o_target = o_target;
         end
      end
   end

endmodule

// File: rtl/fetch_pc_sequencer.sv
// IF-stage fetch address sequencer with in-flight response tagging.
// Optional per-source redirect counters: define FETCH_PC_SEQ_REDIRECT_COUNT_EN.
module fetch_pc_sequencer
   import fetch_pkg::*;
#(
   parameter int              XLEN          = 32,
   parameter int              NUM_REDIRECT  = 4,
   parameter int              FETCH_LATENCY = 2,
   parameter logic [XLEN-1:0] RESET_VECTOR  = '0
) (
   input  logic                            i_clk,
   input  logic                            i_reset,
   input  logic                            i_stall,
   input  logic [NUM_REDIRECT-1:0]         i_redirect_valid,
   input  logic [NUM_REDIRECT*XLEN-1:0]    i_redirect_target,
   output logic [XLEN-1:0]                 o_fetch_pc,
   output logic                            o_fetch_en,
   output logic                            o_resp_valid,
   output logic [XLEN-1:0]                 o_resp_pc,
   output logic                            o_resp_half,
   output logic                            o_holdoff,
   output logic                            o_redirect_fire,
   output logic [$clog2(NUM_REDIRECT)-1:0] o_redirect_src,
   output logic [NUM_REDIRECT*32-1:0]      o_redirect_count
);

   localparam int SRC_W = $clog2(NUM_REDIRECT);

   if (FETCH_LATENCY < 1 || FETCH_LATENCY > FETCH_LATENCY_MAX) begin : g_bad_latency
      $error("fetch_pc_sequencer: FETCH_LATENCY out of range 1..4");
   end
   if (NUM_REDIRECT < 2) begin : g_bad_num_redirect
      $error("fetch_pc_sequencer: NUM_REDIRECT must be at least 2");
   end
   if (XLEN < 4 || XLEN > FETCH_XLEN_MAX) begin : g_bad_xlen
      $error("fetch_pc_sequencer: XLEN out of range");
   end
   if (RESET_VECTOR[1:0] != 2'b00) begin : g_bad_reset_vector
      $error("fetch_pc_sequencer: RESET_VECTOR must be word aligned");
   end

   logic              redirect_fire_s;
   logic [SRC_W-1:0]  redirect_src_s;
   logic [XLEN-1:0]   redirect_tgt_s;
   logic              fetch_en_s;
   logic [XLEN-1:0]   fetch_pc_r;
   logic [XLEN-1:0]   fetch_pc_nxt_s;
   logic              half_pending_r;
   logic              half_pending_nxt_s;
   logic              holdoff_r;
   logic              holdoff_nxt_s;
   fetch_entry_t      push_s;
   fetch_entry_t      pipe_r     [FETCH_LATENCY];
   fetch_entry_t      pipe_nxt_s [FETCH_LATENCY];
   logic              unused_s;

   redirect_priority_arbiter #(
      .N    (NUM_REDIRECT),
      .XLEN (XLEN)
   ) u_arbiter (
      .i_valid  (i_redirect_valid),
      .i_target (i_redirect_target),
      .o_fire   (redirect_fire_s),
      .o_index  (redirect_src_s),
      .o_target (redirect_tgt_s)
   );

   assign fetch_en_s = !i_stall && !i_reset;

   // next fetch address, halfword flag and holdoff
   always_comb begin
      if (redirect_fire_s) begin
         fetch_pc_nxt_s     = {redirect_tgt_s[XLEN-1:2], 2'b00};
         half_pending_nxt_s = redirect_tgt_s[1];
      end else if (fetch_en_s) begin
         fetch_pc_nxt_s     = fetch_pc_r + XLEN'(3'd4);
         half_pending_nxt_s = 1'b0;
      end else begin
         fetch_pc_nxt_s     = fetch_pc_r;
         half_pending_nxt_s = half_pending_r;
      end
      if (redirect_fire_s) begin
         holdoff_nxt_s = 1'b1;
      end else if (pipe_nxt_s[FETCH_LATENCY-1].valid) begin
         holdoff_nxt_s = 1'b0;
      end else begin
         holdoff_nxt_s = holdoff_r;
      end
   end

   // in-flight pipeline next state: shift on issue, squash on redirect
   always_comb begin
      push_s               = '0;
      push_s.valid         = !redirect_fire_s;
      push_s.half          = half_pending_r;
      push_s.pc[XLEN-1:0]  = fetch_pc_r;
      for (int i = 0; i < FETCH_LATENCY; i++) begin
         pipe_nxt_s[i] = pipe_r[i];
      end
      if (fetch_en_s) begin
         pipe_nxt_s[0] = push_s;
         for (int i = 1; i < FETCH_LATENCY; i++) begin
            pipe_nxt_s[i] = pipe_r[i-1];
         end
      end else begin
         pipe_nxt_s[0] = pipe_r[0];
      end
      if (redirect_fire_s) begin
         for (int i = 0; i < FETCH_LATENCY; i++) begin
            pipe_nxt_s[i].valid = 1'b0;
         end
      end else begin
         pipe_nxt_s[0].valid = pipe_nxt_s[0].valid;
      end
   end

   // state registers; reset discards everything in flight
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         fetch_pc_r     <= RESET_VECTOR;
         half_pending_r <= 1'b0;
         holdoff_r      <= 1'b1;
         for (int i = 0; i < FETCH_LATENCY; i++) begin
            pipe_r[i] <= '0;
         end
      end else begin
         fetch_pc_r     <= fetch_pc_nxt_s;
         half_pending_r <= half_pending_nxt_s;
         holdoff_r      <= holdoff_nxt_s;
         for (int i = 0; i < FETCH_LATENCY; i++) begin
            pipe_r[i] <= pipe_nxt_s[i];
         end
      end
   end

`ifdef FETCH_PC_SEQ_REDIRECT_COUNT_EN
   logic [NUM_REDIRECT-1:0][31:0] cnt_r;

   // saturating per-source counters, bumped only for the winning source
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         cnt_r <= '0;
      end else if (redirect_fire_s && (cnt_r[redirect_src_s] != 32'hFFFF_FFFF)) begin
         cnt_r[redirect_src_s] <= cnt_r[redirect_src_s] + 32'd1;
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign o_redirect_count = cnt_r;
`else
   assign o_redirect_count = {(NUM_REDIRECT*32){1'b0}};
`endif

   assign o_fetch_pc      = fetch_pc_r;
   assign o_fetch_en      = fetch_en_s;
   assign o_resp_valid    = pipe_r[FETCH_LATENCY-1].valid;
   assign o_resp_pc       = pipe_r[FETCH_LATENCY-1].pc[XLEN-1:0];
   assign o_resp_half     = pipe_r[FETCH_LATENCY-1].half;
   assign o_holdoff       = holdoff_r;
   assign o_redirect_fire = redirect_fire_s;
   assign o_redirect_src  = redirect_src_s;

   assign unused_s = ^{redirect_tgt_s[0], pipe_r[FETCH_LATENCY-1].pc};

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Directed, table-driven bench for fetch_pc_sequencer (latency 2 main instance,
// latency 1 and 4 instances for the address-wrap sweep).
module tb_fetch_pc_sequencer;
   import fetch_pkg::*;

   typedef struct packed {
      logic         rst;
      logic         stall;
      logic [3:0]   rv;
      logic [127:0] tgt;
      logic [31:0]  e_pc;
      logic         e_valid;
      logic [31:0]  e_rpc;
      logic         e_half;
      logic         e_hold;
      logic [1:0]   e_src;
   } vec_t;

   localparam logic [127:0] JUNK = {32'hAAA0_0000, 32'hBBB0_0000, 32'hCCC0_0000, 32'hDDD0_0000};
   localparam int NVEC = 30;

   logic          i_clk = 1'b0;
   logic          i_reset;
   logic          i_stall;
   logic [3:0]    i_redirect_valid;
   logic [127:0]  i_redirect_target;
   logic [31:0]   o_fetch_pc;
   logic          o_fetch_en;
   logic          o_resp_valid;
   logic [31:0]   o_resp_pc;
   logic          o_resp_half;
   logic          o_holdoff;
   logic          o_redirect_fire;
   logic [1:0]    o_redirect_src;
   logic [127:0]  o_redirect_count;

   logic          z_stall = 1'b0;
   logic [3:0]    z_rv    = 4'd0;
   logic [127:0]  z_tgt   = 128'd0;
   logic [31:0]   l1_pc, l1_rpc, l4_pc, l4_rpc;
   logic          l1_en, l1_valid, l1_half, l1_hold, l1_fire;
   logic          l4_en, l4_valid, l4_half, l4_hold, l4_fire;
   logic [1:0]    l1_src, l4_src;
   logic [127:0]  l1_cnt, l4_cnt;

   int   cmp_cnt = 0;
   int   err_cnt = 0;
   vec_t vecs [NVEC];

   always #5 i_clk = ~i_clk;

   fetch_pc_sequencer #(.XLEN(32), .NUM_REDIRECT(4), .FETCH_LATENCY(2), .RESET_VECTOR(32'h100)) dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_stall(i_stall),
      .i_redirect_valid(i_redirect_valid), .i_redirect_target(i_redirect_target),
      .o_fetch_pc(o_fetch_pc), .o_fetch_en(o_fetch_en), .o_resp_valid(o_resp_valid),
      .o_resp_pc(o_resp_pc), .o_resp_half(o_resp_half), .o_holdoff(o_holdoff),
      .o_redirect_fire(o_redirect_fire), .o_redirect_src(o_redirect_src),
      .o_redirect_count(o_redirect_count));

   fetch_pc_sequencer #(.XLEN(32), .NUM_REDIRECT(4), .FETCH_LATENCY(1), .RESET_VECTOR(32'hFFFF_FFFC)) dut_l1 (
      .i_clk(i_clk), .i_reset(i_reset), .i_stall(z_stall),
      .i_redirect_valid(z_rv), .i_redirect_target(z_tgt),
      .o_fetch_pc(l1_pc), .o_fetch_en(l1_en), .o_resp_valid(l1_valid),
      .o_resp_pc(l1_rpc), .o_resp_half(l1_half), .o_holdoff(l1_hold),
      .o_redirect_fire(l1_fire), .o_redirect_src(l1_src), .o_redirect_count(l1_cnt));

   fetch_pc_sequencer #(.XLEN(32), .NUM_REDIRECT(4), .FETCH_LATENCY(4), .RESET_VECTOR(32'hFFFF_FFFC)) dut_l4 (
      .i_clk(i_clk), .i_reset(i_reset), .i_stall(z_stall),
      .i_redirect_valid(z_rv), .i_redirect_target(z_tgt),
      .o_fetch_pc(l4_pc), .o_fetch_en(l4_en), .o_resp_valid(l4_valid),
      .o_resp_pc(l4_rpc), .o_resp_half(l4_half), .o_holdoff(l4_hold),
      .o_redirect_fire(l4_fire), .o_redirect_src(l4_src), .o_redirect_count(l4_cnt));

   function automatic vec_t row(input logic rst, input logic stall, input logic [3:0] rv,
                                input logic [127:0] tgt, input logic [31:0] e_pc,
                                input logic e_valid, input logic [31:0] e_rpc,
                                input logic e_half, input logic e_hold, input logic [1:0] e_src);
      vec_t v;
      v.rst = rst; v.stall = stall; v.rv = rv; v.tgt = tgt;
      v.e_pc = e_pc; v.e_valid = e_valid; v.e_rpc = e_rpc;
      v.e_half = e_half; v.e_hold = e_hold; v.e_src = e_src;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      cmp_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
      end
   endtask

   task automatic run_rows(input int first, input int last);
      logic [31:0] sweep_pc;
      for (int i = first; i <= last; i++) begin
         i_reset           = vecs[i].rst;
         i_stall           = vecs[i].stall;
         i_redirect_valid  = vecs[i].rv;
         i_redirect_target = vecs[i].tgt;
         #1;
         check($sformatf("row%0d fetch_pc", i), o_fetch_pc, vecs[i].e_pc);
         check($sformatf("row%0d fetch_en", i), {31'd0, o_fetch_en}, {31'd0, !vecs[i].stall && !vecs[i].rst});
         check($sformatf("row%0d resp_valid", i), {31'd0, o_resp_valid}, {31'd0, vecs[i].e_valid});
         check($sformatf("row%0d holdoff", i), {31'd0, o_holdoff}, {31'd0, vecs[i].e_hold});
         check($sformatf("row%0d fire", i), {31'd0, o_redirect_fire}, {31'd0, |vecs[i].rv});
         if (vecs[i].e_valid) begin
            check($sformatf("row%0d resp_pc", i), o_resp_pc, vecs[i].e_rpc);
            check($sformatf("row%0d resp_half", i), {31'd0, o_resp_half}, {31'd0, vecs[i].e_half});
         end
         if (|vecs[i].rv) begin
            check($sformatf("row%0d src", i), {30'd0, o_redirect_src}, {30'd0, vecs[i].e_src});
         end
         // latency 1 / 4 instances run from reset alongside the first rows
         if (i <= 6) begin
            sweep_pc = 32'hFFFF_FFFC + 32'(i) * 32'd4;
            check($sformatf("l1 row%0d fetch_pc", i), l1_pc, sweep_pc);
            check($sformatf("l1 row%0d resp_valid", i), {31'd0, l1_valid}, {31'd0, (i >= 1)});
            check($sformatf("l4 row%0d resp_valid", i), {31'd0, l4_valid}, {31'd0, (i >= 4)});
            check($sformatf("l4 row%0d holdoff", i), {31'd0, l4_hold}, {31'd0, (i < 4)});
            if (i >= 1) check($sformatf("l1 row%0d resp_pc", i), l1_rpc, sweep_pc - 32'd4);
            if (i >= 4) check($sformatf("l4 row%0d resp_pc", i), l4_rpc, sweep_pc - 32'd16);
         end
         @(posedge i_clk);
         #1;
      end
   endtask

   initial begin
      //              rst   stall rv       tgt                                             pc         vld  rpc        half hold src
      vecs[0]  = row(1'b0, 1'b0, 4'b0000, JUNK,                                          32'h100, 1'b0, 32'h0,   1'b0, 1'b1, 2'd0);
      vecs[1]  = row(1'b0, 1'b0, 4'b0000, JUNK,                                          32'h104, 1'b0, 32'h0,   1'b0, 1'b1, 2'd0);
      vecs[2]  = row(1'b0, 1'b0, 4'b0000, JUNK,                                          32'h108, 1'b1, 32'h100, 1'b0, 1'b0, 2'd0);
      vecs[3]  = row(1'b0, 1'b0, 4'b0000, JUNK,                                          32'h10C, 1'b1, 32'h104, 1'b0, 1'b0, 2'd0);
      vecs[4]  = row(1'b0, 1'b0, 4'b0000, JUNK,                                          32'h110, 1'b1, 32'h108, 1'b0, 1'b0, 2'd0);
      vecs[5]  = row(1'b0, 1'b0, 4'b0010, {32'hAAA0_0000, 32'hBBB0_0000, 32'h206, 32'hDDD0_0000},
                                                                                         32'h114, 1'b1, 32'h10C, 1'b0, 1'b0, 2'd1);
      vecs[6]  = row(1'b0, 1'b0, 4'b0000, JUNK,                                          32'h204, 1'b0, 32'h0,   1'b0, 1'b1, 2'd0);
      vecs[7]  = row(1'b0, 1'b0, 4'b0000, JUNK,                                          32'h208, 1'b0, 32'h0,   1'b0, 1'b1, 2'd0);
      vecs[8]  = row(1'b0, 1'b0, 4'b0000, JUNK,                                          32'h20C, 1'b1, 32'h204, 1'b1, 1'b0, 2'd0);
      vecs[9]  = row(1'b0, 1'b0, 4'b0000, JUNK,                                          32'h210, 1'b1, 32'h208, 1'b0, 1'b0, 2'd0);
      vecs[10] = row(1'b0, 1'b0, 4'b0101, {32'hAAA0_0000, 32'h400, 32'hCCC0_0000, 32'h80},
                                                                                         32'h214, 1'b1, 32'h20C, 1'b0, 1'b0, 2'd0);
      vecs[11] = row(1'b0, 1'b0, 4'b0000, JUNK,                                          32'h80,  1'b0, 32'h0,   1'b0, 1'b1, 2'd0);
      vecs[12] = row(1'b0, 1'b0, 4'b0000, JUNK,                                          32'h84,  1'b0, 32'h0,   1'b0, 1'b1, 2'd0);
      vecs[13] = row(1'b0, 1'b0, 4'b0000, JUNK,                                          32'h88,  1'b1, 32'h80,  1'b0, 1'b0, 2'd0);
      vecs[14] = row(1'b0, 1'b1, 4'b0000, JUNK,                                          32'h8C,  1'b1, 32'h84,  1'b0, 1'b0, 2'd0);
      vecs[15] = row(1'b0, 1'b1, 4'b0100, {32'hAAA0_0000, 32'h301, 32'hCCC0_0000, 32'hDDD0_0000},
                                                                                         32'h8C,  1'b1, 32'h84,  1'b0, 1'b0, 2'd2);
      vecs[16] = row(1'b0, 1'b1, 4'b0000, JUNK,                                          32'h300, 1'b0, 32'h0,   1'b0, 1'b1, 2'd0);
      vecs[17] = row(1'b0, 1'b0, 4'b0000, JUNK,                                          32'h300, 1'b0, 32'h0,   1'b0, 1'b1, 2'd0);
      vecs[18] = row(1'b0, 1'b0, 4'b0000, JUNK,                                          32'h304, 1'b0, 32'h0,   1'b0, 1'b1, 2'd0);
      vecs[19] = row(1'b0, 1'b0, 4'b0000, JUNK,                                          32'h308, 1'b1, 32'h300, 1'b0, 1'b0, 2'd0);
      vecs[20] = row(1'b0, 1'b0, 4'b1000, {32'h40, 32'hBBB0_0000, 32'hCCC0_0000, 32'hDDD0_0000},
                                                                                         32'h30C, 1'b1, 32'h304, 1'b0, 1'b0, 2'd3);
      vecs[21] = row(1'b0, 1'b0, 4'b0010, {32'hAAA0_0000, 32'hBBB0_0000, 32'h80, 32'hDDD0_0000},
                                                                                         32'h40,  1'b0, 32'h0,   1'b0, 1'b1, 2'd1);
      vecs[22] = row(1'b0, 1'b0, 4'b0000, JUNK,                                          32'h80,  1'b0, 32'h0,   1'b0, 1'b1, 2'd0);
      vecs[23] = row(1'b0, 1'b0, 4'b0000, JUNK,                                          32'h84,  1'b0, 32'h0,   1'b0, 1'b1, 2'd0);
      vecs[24] = row(1'b0, 1'b0, 4'b0000, JUNK,                                          32'h88,  1'b1, 32'h80,  1'b0, 1'b0, 2'd0);
      vecs[25] = row(1'b0, 1'b0, 4'b0000, JUNK,                                          32'h8C,  1'b1, 32'h84,  1'b0, 1'b0, 2'd0);
      // reset with a concurrent redirect: reset must win
      vecs[26] = row(1'b1, 1'b0, 4'b0001, {32'hAAA0_0000, 32'hBBB0_0000, 32'hCCC0_0000, 32'h500},
                                                                                         32'h90,  1'b1, 32'h88,  1'b0, 1'b0, 2'd0);
      vecs[27] = row(1'b0, 1'b0, 4'b0000, JUNK,                                          32'h100, 1'b0, 32'h0,   1'b0, 1'b1, 2'd0);
      vecs[28] = row(1'b0, 1'b0, 4'b0000, JUNK,                                          32'h104, 1'b0, 32'h0,   1'b0, 1'b1, 2'd0);
      vecs[29] = row(1'b0, 1'b0, 4'b0000, JUNK,                                          32'h108, 1'b1, 32'h100, 1'b0, 1'b0, 2'd0);

      i_reset           = 1'b1;
      i_stall           = 1'b0;
      i_redirect_valid  = 4'd0;
      i_redirect_target = 128'd0;
      repeat (3) @(posedge i_clk);
      #1;
      check("reset count", o_redirect_count[31:0] | o_redirect_count[63:32] |
                           o_redirect_count[95:64] | o_redirect_count[127:96], 32'd0);

      run_rows(0, 25);

`ifdef FETCH_PC_SEQ_REDIRECT_COUNT_EN
      check("count trap",   o_redirect_count[32*REDIR_TRAP   +: 32], 32'd1);
      check("count branch", o_redirect_count[32*REDIR_BRANCH +: 32], 32'd2);
      check("count pred",   o_redirect_count[32*REDIR_PRED   +: 32], 32'd1);
      check("count spare",  o_redirect_count[32*REDIR_SPARE  +: 32], 32'd1);
`else
      check("count tied trap",   o_redirect_count[31:0],   32'd0);
      check("count tied branch", o_redirect_count[63:32],  32'd0);
`endif

      run_rows(26, 29);
      check("count after reset", o_redirect_count[31:0] | o_redirect_count[63:32] |
                                 o_redirect_count[95:64] | o_redirect_count[127:96], 32'd0);

`ifdef FETCH_PC_SEQ_REDIRECT_COUNT_EN
      force dut.cnt_r = {96'd0, 32'hFFFF_FFFE};
      #1;
      release dut.cnt_r;
      i_redirect_valid  = 4'b0001;
      i_redirect_target = {96'd0, 32'h10};
      @(posedge i_clk);
      #1;
      check("count reach max", o_redirect_count[31:0], 32'hFFFF_FFFF);
      @(posedge i_clk);
      #1;
      check("count saturate", o_redirect_count[31:0], 32'hFFFF_FFFF);
      check("count other src", o_redirect_count[63:32], 32'd0);
      i_redirect_valid = 4'd0;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

endmodule
